// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state type and accumulator width helper for the FIR MAC stage
package fir_pkg;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    function automatic int acc_width(input int taps);
        return PROD_W + $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: sample, coefficient and result handshake bundle of the FIR MAC stage
interface fir_mac_seq_if import fir_pkg::*; #(
    parameter int TAPS = 8,
    parameter int ACC_W = acc_width(TAPS)
);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic coef_we;
    logic [$clog2(TAPS)-1:0] coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic out_valid;
    logic out_ready;
    logic [ACC_W-1:0] out_data;
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input in_ready, out_valid, out_data
    );
    modport slave (
        input in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x 8 coefficient register file, sync write, combinational read
module fir_coef_bank import fir_pkg::*; #(
    parameter int TAPS = 8
) (
    input logic clk,
    input logic rst_n,
    input logic we,
    input logic [$clog2(TAPS)-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [$clog2(TAPS)-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] c [TAPS];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) c[i] <= '0;
        end else if (we && 32'(waddr) < TAPS) begin
            c[waddr] <= wdata;
        end
    end
    assign rdata = c[raddr];
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR stage, one 8x8 multiply per cycle over a TAPS-deep delay line
// Define FIR_SAT_EN to clamp out_data to 16 bits for a 16-bit downstream.
module fir_mac_seq import fir_pkg::*; #(
    parameter int TAPS = 8,
    parameter int ACC_W = acc_width(TAPS)
) (
    input logic clk,
    input logic rst_n,
    fir_mac_seq_if.slave bus
);
    localparam int AW = $clog2(TAPS);
    state_t state, state_nxt;
    logic [DATA_W-1:0] x [TAPS];
    logic [AW-1:0] idx;
    logic [ACC_W-1:0] acc, acc_nxt, res;
    logic [DATA_W-1:0] coef;
    logic [PROD_W-1:0] prod;
    logic accept, last;
    // coefficient writes only land in IDLE so one result never mixes coefficient sets
    fir_coef_bank #(.TAPS(TAPS)) u_coef (
        .clk(clk),
        .rst_n(rst_n),
        .we(bus.coef_we && state == IDLE),
        .waddr(bus.coef_addr),
        .wdata(bus.coef_data),
        .raddr(idx),
        .rdata(coef)
    );
    always_comb begin
        bus.in_ready = state == IDLE && rst_n;
        bus.out_valid = state == OUT && rst_n;
        accept = bus.in_valid && bus.in_ready;
        last = idx == AW'(TAPS - 1);
        prod = x[idx] * coef;
        acc_nxt = acc + ACC_W'(prod);
`ifdef FIR_SAT_EN
        res = (acc_nxt > ACC_W'(17'h0FFFF)) ? ACC_W'(16'hFFFF) : acc_nxt;
`else
        res = acc_nxt;
`endif
        state_nxt = accept ? MAC
                  : (state == MAC && last) ? OUT
                  : (state == OUT && bus.out_ready) ? IDLE
                  : state;
    end
    always_ff @(posedge clk) begin
        state <= rst_n ? state_nxt : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) x[k] <= '0;
            acc <= '0;
            idx <= '0;
            bus.out_data <= '0;
        end else begin
            if (accept) begin
                x[0] <= bus.in_data;
                for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
                acc <= '0;
                idx <= '0;
            end
            if (state == MAC) begin
                acc <= acc_nxt;
                idx <= idx + 1'b1;
                if (last) bus.out_data <= res;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed vector table plus hand-written multi-cycle sequences for fir_mac_seq
module tb_fir_mac_seq;
    localparam int TAPS = 8;
    localparam int ACC_W = 19;
    typedef struct {
        bit cs;
        logic [7:0] d;
        int e;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    vec_t tv [17];
    fir_mac_seq_if #(.TAPS(TAPS), .ACC_W(ACC_W)) bus ();
    fir_mac_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int expv(input int v);
`ifdef FIR_SAT_EN
        return v > 65535 ? 65535 : v;
`else
        return v;
`endif
    endfunction
    task automatic chk(input string nm, input longint a, input longint e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask
    task automatic wcoef(input int a, input int v);
        bus.coef_we = 1'b1;
        bus.coef_addr = 3'(a);
        bus.coef_data = 8'(v);
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
    endtask
    task automatic load_coefs(input bit full);
        for (int i = 0; i < TAPS; i++) wcoef(i, full ? 255 : i + 1);
    endtask
    // accept one sample, optionally poke c[0] during the first MAC cycle, wait for the result
    task automatic run(input logic [7:0] d, input bit mac_wr, input bit hs,
                       output logic [ACC_W-1:0] r, output int lat, output int acc_at);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data = d;
        @(posedge clk);
        #1;
        acc_at = cyc;
        bus.in_valid = 1'b0;
        bus.coef_we = mac_wr;
        bus.coef_addr = '0;
        bus.coef_data = 8'd9;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            bus.coef_we = 1'b0;
            lat++;
        end
        r = bus.out_data;
        if (hs) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [ACC_W-1:0] r;
        int lat, at, prev;
        bit loaded;
        for (int i = 0; i < 9; i++) tv[i] = '{1'b0, (i == 0) ? 8'd1 : 8'd0, (i < 8) ? i + 1 : 0};
        for (int i = 9; i < 17; i++) tv[i] = '{1'b1, 8'd255, (i - 8) * 65025};
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_out_valid", bus.out_valid, 0);
        chk("rel_out_data", bus.out_data, 0);
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            loaded = (i == 0) || (tv[i].cs != tv[i-1].cs);
            if (loaded) load_coefs(tv[i].cs);
            run(tv[i].d, 1'b0, 1'b1, r, lat, at);
            chk($sformatf("vec%0d", i), r, expv(tv[i].e));
            chk($sformatf("lat%0d", i), lat, 9);
            if (!loaded) chk($sformatf("b2b%0d", i), at - prev, 10);
            prev = at;
        end
        load_coefs(1'b0);
        bus.out_ready = 1'b0;
        run(8'd3, 1'b0, 1'b0, r, lat, at);
        chk("bp_val", r, 8928);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_data", bus.out_data, 8928);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ready", bus.in_ready, 1);
        chk("bp_idle_valid", bus.out_valid, 0);
        run(8'd1, 1'b1, 1'b1, r, lat, at);
        chk("gate_cur", r, 8422);
        run(8'd4, 1'b0, 1'b1, r, lat, at);
        chk("gate_next", r, 7665);
        wcoef(0, 9);
        run(8'd2, 1'b0, 1'b1, r, lat, at);
        chk("gate_idle_wr", r, 6671);
        bus.in_valid = 1'b1;
        bus.in_data = 8'd5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_ready", bus.in_ready, 1);
        chk("mrst_rel_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        chk("mrst_post_valid", bus.out_valid, 0);
        load_coefs(1'b0);
        for (int i = 0; i < TAPS; i++) begin
            run((i == 0) ? 8'd1 : 8'd0, 1'b0, 1'b1, r, lat, at);
            chk($sformatf("mrst_imp%0d", i), r, i + 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
